int_to_fp_seq: RTL and testbench

- Sequential encoder from a two's-complement integer to the team's 13-bit floating-point format: sign, 4-bit exp, 8-bit frac.
- Produces operands for fp_adder in hardware, replacing hand-built frac/exp constants on the switch and button inputs.
- Normalizes by shifting one bit per clock under a start/ready/done_tick handshake.
- Result drives fp_adder inputs, or the hex_to_sseg/disp_mux display path.

---
 rtl/fp_fmt_pkg.sv | 19 +
 rtl/int_to_fp_seq.sv | 93 +++++++++
 tb/tb_int_to_fp_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fp_fmt_pkg.sv
// Shared 13-bit float format definitions: sign, 4-bit exponent, 8-bit fraction.
// Used by the int-to-fp encoder, fp_adder and fp-to-int blocks.
package fp_fmt_pkg;

  localparam int EXP_W  = 4;
  localparam int FRAC_W = 8;

  // Canonical encoding of zero: positive sign, zero exponent, zero fraction
  localparam logic              SIGN_ZERO = 1'b0;
  localparam logic [EXP_W-1:0]  EXP_ZERO  = '0;
  localparam logic [FRAC_W-1:0] FRAC_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } fp_state_e;

endpackage

// File: rtl/int_to_fp_seq.sv
// Sequential two's-complement integer to 13-bit float encoder.
// Captures |din| and normalizes it one left shift per clock until the MSB is
// set, decrementing the exponent on each shift. Result is truncated.
module int_to_fp_seq
  import fp_fmt_pkg::*;
#(
  parameter int IN_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IN_W-1:0]   din,
  output logic              ready,
  output logic              done_tick,
  output logic              sign_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [FRAC_W-1:0] frac_out
);

  fp_state_e         state_q, state_d;
  logic [IN_W-1:0]   mag_q,   mag_d;
  logic [EXP_W-1:0]  exp_q,   exp_d;
  logic              sgn_q,   sgn_d;

  // Magnitude of the input; -2^(IN_W-1) wraps to 1 followed by zeros, which
  // is exactly its unsigned magnitude.
  logic signed [IN_W-1:0] din_s;
  logic        [IN_W-1:0] din_abs;
  assign din_s   = din;
  assign din_abs = din_s[IN_W-1] ? $unsigned(-din_s) : $unsigned(din_s);

  // State and datapath registers; reset also clears the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mag_q   <= '0;
      exp_q   <= EXP_ZERO;
      sgn_q   <= SIGN_ZERO;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      sgn_q   <= sgn_d;
    end
  end

  // Next-state and normalization step: one rule per edge while in NORM.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    sgn_d   = sgn_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sgn_d   = din[IN_W-1];
          mag_d   = din_abs;
          exp_d   = EXP_W'(IN_W);
          state_d = NORM;
        end
      end
      NORM: begin
        if (mag_q == '0) begin
          sgn_d   = SIGN_ZERO;
          exp_d   = EXP_ZERO;
          state_d = DONE;
        end else if (mag_q[IN_W-1]) begin
          state_d = DONE;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - EXP_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore handshake outputs decoded from the state.
  always_comb begin
    ready     = (state_q == IDLE);
    done_tick = (state_q == DONE);
  end

  assign sign_out = sgn_q;
  assign exp_out  = exp_q;
  assign frac_out = mag_q[IN_W-1 -: FRAC_W];

endmodule

// File: tb/tb_int_to_fp_seq.sv
// Directed bench for int_to_fp_seq with IN_W=12.
module tb_int_to_fp_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [11:0] din;
  logic        ready;
  logic        done_tick;
  logic        sign_out;
  logic [3:0]  exp_out;
  logic [7:0]  frac_out;

  int vec;
  int miscomp;
  int inj_at;
  logic [11:0] inj_val;

  int_to_fp_seq #(.IN_W(12)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din       (din),
    .ready     (ready),
    .done_tick (done_tick),
    .sign_out  (sign_out),
    .exp_out   (exp_out),
    .frac_out  (frac_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miscomp++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for ready, presents din with start for one accepting edge, then
  // counts edges until done_tick and checks latency and result.
  task automatic conv(input string tag, input logic [11:0] d, input int lat,
                      input logic es, input logic [3:0] ee, input logic [7:0] ef);
    int cnt;
    int guard;
    logic ready_seen;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_ready_before"}, {31'd0, ready}, 32'd1);
    din   = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cnt = 0;
    ready_seen = 1'b0;
    while (!done_tick && cnt < 40) begin
      if (ready) ready_seen = 1'b1;
      @(posedge clk);
      #1;
      cnt++;
      start = 1'b0;
      if (cnt == inj_at) begin
        din   = inj_val;
        start = 1'b1;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, cnt, lat);
    check({tag, "_ready_busy"}, {31'd0, ready_seen}, 32'd0);
    check({tag, "_sign"}, {31'd0, sign_out}, {31'd0, es});
    check({tag, "_exp"}, {28'd0, exp_out}, {28'd0, ee});
    check({tag, "_frac"}, {24'd0, frac_out}, {24'd0, ef});
  endtask

  initial begin
    vec     = 0;
    miscomp = 0;
    inj_at  = 0;
    inj_val = '0;
    reset   = 1'b1;
    start   = 1'b0;
    din     = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, done_tick}, 32'd0);
    check("rst_sign", {31'd0, sign_out}, 32'd0);
    check("rst_exp", {28'd0, exp_out}, 32'd0);
    check("rst_frac", {24'd0, frac_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // longest normalization and most negative input
    conv("one",   12'h001, 12, 1'b0, 4'd1,  8'h80);
    conv("min",   12'h800, 1,  1'b1, 4'd12, 8'h80);
    // truncation of 2047 -> 2040
    conv("max",   12'h7FF, 2,  1'b0, 4'd11, 8'hFF);
    conv("neg3",  12'hFFD, 11, 1'b1, 4'd2,  8'hC0);
    conv("zero",  12'h000, 1,  1'b0, 4'd0,  8'h00);
    conv("x1a5",  12'h1A5, 4,  1'b0, 4'd9,  8'hD2);

    // result held through idle cycles
    repeat (3) @(posedge clk);
    #1;
    check("hold_exp", {28'd0, exp_out}, 32'd9);
    check("hold_frac", {24'd0, frac_out}, 32'hD2);
    check("hold_done", {31'd0, done_tick}, 32'd0);

    // start pulsed mid-normalization is ignored
    inj_at  = 4;
    inj_val = 12'h800;
    conv("ign",   12'h001, 12, 1'b0, 4'd1,  8'h80);
    inj_at  = 0;
    // back-to-back: conv waits only for the ready cycle right after done_tick
    conv("b2b",   12'hFFD, 11, 1'b1, 4'd2,  8'hC0);

    // reset in the middle of a conversion
    @(negedge clk);
    din   = 12'h001;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_ready", {31'd0, ready}, 32'd1);
    check("mrst_done", {31'd0, done_tick}, 32'd0);
    check("mrst_sign", {31'd0, sign_out}, 32'd0);
    check("mrst_exp", {28'd0, exp_out}, 32'd0);
    check("mrst_frac", {24'd0, frac_out}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    begin
      logic seen_done;
      seen_done = 1'b0;
      repeat (15) begin
        @(posedge clk);
        #1;
        if (done_tick) seen_done = 1'b1;
      end
      check("mrst_no_done", {31'd0, seen_done}, 32'd0);
      check("mrst_idle", {31'd0, ready}, 32'd1);
    end
    conv("after", 12'h7FF, 2,  1'b0, 4'd11, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscomp);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
